gate_vector_checker: RTL

Synthesizable exhaustive tester for a two-input, one-output combinational gate. On `start` it drives all four `{a,b}` input combinations in ascending order, holds each for a programmable number of cycles, and samples the gate output `c`. It compares each sample against a parameterised truth table and reports per-vector failures, an error count and a pass flag. It is the checking counterpart to the gate modules' stimulus benches, so gates such as the NAND can be proven in hardware.

---
 rtl/gate_vector_checker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gate_vector_checker.sv
// Exhaustive two-input gate tester: walks {a,b} through 00..11 and scores c.
// Define GATE_CHK_SYNC_EN to pass c through a two-flop synchronizer first.
module gate_vector_checker #(
  parameter int         HOLD_CYCLES = 100,
  parameter logic [3:0] TRUTH       = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    err_q, err_d;
  logic [3:0]    fail_q, fail_d;
  logic [1:0]    ab_q, ab_d;
  logic          c_cmp;

`ifdef GATE_CHK_SYNC_EN
  logic c_s1_q, c_s2_q;

  if (HOLD_CYCLES < 3) begin : g_hold_chk
    $error("HOLD_CYCLES must be >= 3 with the c synchronizer");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_s1_q <= 1'b0;
      c_s2_q <= 1'b0;
    end else begin
      c_s1_q <= c;
      c_s2_q <= c_s1_q;
    end
  end

  assign c_cmp = c_s2_q;
`else
  assign c_cmp = c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
      ab_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      ab_q    <= ab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fail_d  = fail_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          hold_d  = '0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
        end
      end
      DRIVE: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_LAST) begin
          if (c_cmp != TRUTH[idx_q]) begin
            fail_d[idx_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          hold_d = '0;
          if (idx_q == 2'd3) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // a/b come straight off a flop, so precompute them from next state
    ab_d = (state_d == DRIVE) ? idx_d : 2'b00;
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = (state_q == DRIVE);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == 3'd0);
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
